exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception and interrupt sequencer for the multicycle MIPS core. Each instruction commits for one cycle. At that commit point the block picks the highest-priority enabled trap: syscall, break, teq or an external interrupt. It then drives the CP0 register file through a fixed save-then-redirect sequence, and sequences eret through restore-then-return. It sits between the decode/commit logic, the CP0 block and the PC mux, and stalls the core while a sequence is in flight.

## Interface
- EXC_VECTOR, 32'h0000_0004, handler entry address.
- IRQ_W, 6, number of external interrupt lines.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instr_valid  in  1  an instruction commits this cycle.
- instr_pc  in  32  PC of the committing instruction.
- syscall, brk, teq_trap  in  1 each  decoded trap condition of the committing instruction (teq_trap already includes rs==rt).
- eret  in  1  committing instruction is eret.
- irq  in  IRQ_W  asynchronous level interrupt lines.
- status  in  32  CP0 status. Bit 0 is the global IE. Bits 1/2/3/4 enable syscall/break/teq/irq.
- epc_in  in  32  CP0 EPC read-back.
- take  out  1  combinational; the committing instruction is trapped, so suppress its writeback.
- exception  out  1  one-cycle strobe to CP0 (write status/cause/epc).
- cp0_eret  out  1  one-cycle strobe to CP0 (restore status).
- cause  out  32  cause word to CP0.
- epc_pc  out  32  value CP0 latches as EPC.
- pc_redirect  out  1  one-cycle PC override.
- redirect_pc  out  32  PC override target.
- stall  out  1  freeze fetch/commit.
- irq_pending  out  IRQ_W  latched pending interrupts.

## Operation
- **States:** IDLE, SAVE, VECTOR, RESTORE, RETURN.
- **Enable:** source s is enabled when status[0] & status[bit_s].
- **Priority at commit** (instr_valid=1, state IDLE): syscall > brk > teq_trap > any irq_pending (lowest index first when encoding is needed) > eret.
  - Disabled sources are ignored. The instruction completes normally.
- **Trap entry:**
  - take=1. Register the cause and EPC, then go to SAVE.
  - ExcCode goes in cause[6:2]: syscall 8, break 9, teq 13, interrupt 0.
  - cause[15:10] = irq_pending snapshot. All other cause bits are 0.
  - epc_pc = instr_pc+4 for syscall/break/teq, and instr_pc for an interrupt (the instruction re-executes).
- **SAVE:** exception=1. Next state VECTOR.
- **VECTOR:** pc_redirect=1, redirect_pc=EXC_VECTOR. Clear the pending bits that were captured in cause. Next state IDLE.
- **Eret** (committing, no trap taken): go to RESTORE.
  - RESTORE: cp0_eret=1. Next state RETURN.
  - RETURN: pc_redirect=1, redirect_pc=epc_in. Next state IDLE.
- **stall:** 1 in every non-IDLE state; 0 in IDLE.
- **Interrupt capture:**
  - irq passes through a 2-flop synchronizer.
  - A rising edge of a synchronized line sets its pending bit.
  - A bit clears only in VECTOR, and only when it was captured.
  - An edge arriving in the same cycle as the clear wins, so the bit stays set.
- **Arithmetic:** instr_pc+4 is 32-bit modulo. 32'hFFFF_FFFC wraps to 0.

## Timing
- **Reset** (rst=0, asynchronous): state IDLE, synchronizers and pending cleared. exception, cp0_eret, pc_redirect, stall, take, cause, epc_pc, redirect_pc and irq_pending are all 0.
- **Trap latency:** commit edge N → exception high in cycle N+1 → pc_redirect in N+2 → IDLE in N+3.
- **Eret latency:** same shape. RESTORE in N+1, RETURN in N+2. epc_in is sampled in RETURN.
- **Irq latency:** irq high → pending set 3 edges later. The interrupt is taken at the first commit after that.
- instr_valid outside IDLE is ignored. stall guarantees it is 0.
- **Trap and eret in one commit:** the trap wins and eret is dropped.
- **Reset mid-sequence:** return to IDLE immediately and drop the strobes. CP0 is reset by the same rst.
- cause, epc_pc and redirect_pc hold their last values in IDLE.

## Structure
- Package exc_pkg: state enum, ExcCode constants (EXC_INT=0, EXC_SYS=8, EXC_BP=9, EXC_TR=13), status bit indices (ST_IE=0, ST_SYS=1, ST_BP=2, ST_TR=3, ST_INT=4).
- Sub-module irq_latch: synchronizer, edge detect and sticky pending register with clear mask.
- exc_ctrl contains the priority encode, FSM and output registers.

## Test plan
- **Syscall taken:** status=32'h3, instr_pc=32'h0040_0010, syscall=1.
  - take=1 that cycle.
  - Next cycle: exception=1, cause=32'h20, epc_pc=32'h0040_0014.
  - Cycle after: pc_redirect=1, redirect_pc=32'h4.
- **Masked:** status=32'h1, brk=1 → take=0, no strobes, stall stays 0.
- **Priority:** status=32'h1F, syscall=1, teq_trap=1, irq[2] pending.
  - cause[6:2]=8 and cause[12]=1.
  - irq[2] is still pending afterwards and is taken at the next commit with cause=32'h1000 and epc_pc equal to that instr_pc.
- **Eret:** epc_in=32'h0040_0014, eret=1.
  - cp0_eret=1 for one cycle.
  - Next cycle pc_redirect=1, redirect_pc=32'h0040_0014.
  - stall=1 for exactly 2 cycles.
- **Edge/clear race:** a new rising edge on the captured irq line lands in the VECTOR cycle → the pending bit is still 1 afterwards.
- **Reset mid-SAVE:** rst=0 asynchronously → exception drops at once, all outputs 0. After release the first commit is handled normally.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
// Cause layout: [15:10] pending snapshot, [6:2] ExcCode, all other bits zero.
package exc_pkg;

  localparam int          IRQ_W      = 6;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_0004;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_VECTOR,
    S_RESTORE,
    S_RETURN
  } state_e;

  localparam logic [4:0] EXC_INT = 5'd0;
  localparam logic [4:0] EXC_SYS = 5'd8;
  localparam logic [4:0] EXC_BP  = 5'd9;
  localparam logic [4:0] EXC_TR  = 5'd13;

  localparam int ST_IE  = 0;
  localparam int ST_SYS = 1;
  localparam int ST_BP  = 2;
  localparam int ST_TR  = 3;
  localparam int ST_INT = 4;

  function automatic logic [31:0] make_cause(input logic [4:0]       code,
                                             input logic [IRQ_W-1:0] pend);
    return {16'h0000, pend, 3'b000, code, 2'b00};
  endfunction

endpackage

// File: rtl/irq_latch.sv
// Interrupt capture: 2-flop synchronizer, rising-edge detect and sticky
// pending bits. A new edge beats a clear landing in the same cycle.
module irq_latch
  import exc_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [IRQ_W-1:0] i_irq,
  input  logic             i_clr_en,
  input  logic [IRQ_W-1:0] i_clr_mask,
  output logic [IRQ_W-1:0] o_pending
);

  logic [IRQ_W-1:0] r_sync1;
  logic [IRQ_W-1:0] r_sync2;
  logic [IRQ_W-1:0] r_prev;
  logic [IRQ_W-1:0] r_pending;
  logic [IRQ_W-1:0] w_rise;
  logic [IRQ_W-1:0] w_clr;

  assign w_rise = r_sync2 & ~r_prev;
  assign w_clr  = i_clr_en ? i_clr_mask : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= '0;
      r_sync2   <= '0;
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_sync1   <= i_irq;
      r_sync2   <= r_sync1;
      r_prev    <= r_sync2;
      r_pending <= (r_pending & ~w_clr) | w_rise;
    end
  end

  assign o_pending = r_pending;

endmodule

// File: rtl/exc_ctrl.sv
// Trap/eret sequencer between commit, CP0 and the PC mux.
//   state     | meaning
//   S_IDLE    | waiting for a commit; trap or eret decided combinationally
//   S_SAVE    | exception strobe, CP0 latches status/cause/epc
//   S_VECTOR  | redirect to EXC_VECTOR, clear interrupts captured in cause
//   S_RESTORE | cp0_eret strobe, CP0 restores status
//   S_RETURN  | redirect to epc_in
module exc_ctrl
  import exc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr_pc,
  input  logic             syscall,
  input  logic             brk,
  input  logic             teq_trap,
  input  logic             eret,
  input  logic [IRQ_W-1:0] irq,
  input  logic [31:0]      status,
  input  logic [31:0]      epc_in,
  output logic             take,
  output logic             exception,
  output logic             cp0_eret,
  output logic [31:0]      cause,
  output logic [31:0]      epc_pc,
  output logic             pc_redirect,
  output logic [31:0]      redirect_pc,
  output logic             stall,
  output logic [IRQ_W-1:0] irq_pending
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [31:0]      r_cause;
  logic [31:0]      r_epc_pc;
  logic [31:0]      r_redirect_pc;
  logic [IRQ_W-1:0] w_pending;
  logic             w_sys, w_bp, w_tr, w_int, w_sw_trap;
  logic             w_commit, w_trap, w_clr_en;
  logic [4:0]       w_code;
  logic [31:0]      w_epc;

  irq_latch u_irq_latch (
    .i_clk      (clk),
    .i_rst_n    (rst),
    .i_irq      (irq),
    .i_clr_en   (w_clr_en),
    .i_clr_mask (r_cause[15:10]),
    .o_pending  (w_pending)
  );

  // Only an interrupt entry clears pending bits; a software trap merely reports them.
  assign w_clr_en = (r_state == S_VECTOR) && (r_cause[6:2] == EXC_INT);

  always_comb begin
    w_sys     = syscall  & status[ST_IE] & status[ST_SYS];
    w_bp      = brk      & status[ST_IE] & status[ST_BP];
    w_tr      = teq_trap & status[ST_IE] & status[ST_TR];
    w_int     = (|w_pending) & status[ST_IE] & status[ST_INT];
    w_sw_trap = w_sys | w_bp | w_tr;
    w_commit  = instr_valid && (r_state == S_IDLE);
    w_trap    = w_commit && (w_sw_trap || w_int);
    if (w_sys)      w_code = EXC_SYS;
    else if (w_bp)  w_code = EXC_BP;
    else if (w_tr)  w_code = EXC_TR;
    else            w_code = EXC_INT;
    w_epc = w_sw_trap ? instr_pc + 32'd4 : instr_pc;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_trap)                w_state_nxt = S_SAVE;
        else if (w_commit && eret) w_state_nxt = S_RESTORE;
      end
      S_SAVE:    w_state_nxt = S_VECTOR;
      S_VECTOR:  w_state_nxt = S_IDLE;
      S_RESTORE: w_state_nxt = S_RETURN;
      S_RETURN:  w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cause       <= '0;
      r_epc_pc      <= '0;
      r_redirect_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_trap) begin
        r_cause  <= make_cause(w_code, w_pending);
        r_epc_pc <= w_epc;
      end
      if (r_state == S_VECTOR)      r_redirect_pc <= EXC_VECTOR;
      else if (r_state == S_RETURN) r_redirect_pc <= epc_in;
    end
  end

  // redirect_pc follows epc_in live in S_RETURN and holds the last target in S_IDLE.
  always_comb begin
    take        = w_trap;
    exception   = (r_state == S_SAVE);
    cp0_eret    = (r_state == S_RESTORE);
    pc_redirect = (r_state == S_VECTOR) || (r_state == S_RETURN);
    stall       = (r_state != S_IDLE);
    cause       = r_cause;
    epc_pc      = r_epc_pc;
    irq_pending = w_pending;
    redirect_pc = r_redirect_pc;
    if (r_state == S_VECTOR)      redirect_pc = EXC_VECTOR;
    else if (r_state == S_RETURN) redirect_pc = epc_in;
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed and randomized checks of exc_ctrl against a behavioural model of
// trap priority, cause/epc formation and the pending-interrupt set.
module tb_exc_ctrl;

  logic        clk, rst, instr_valid, syscall, brk, teq_trap, eret;
  logic [31:0] instr_pc, status, epc_in;
  logic [5:0]  irq;
  logic        take, exception, cp0_eret, pc_redirect, stall;
  logic [31:0] cause, epc_pc, redirect_pc;
  logic [5:0]  irq_pending;

  int          n_assert, n_fail;
  logic [5:0]  m_pend;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_pc(instr_pc),
    .syscall(syscall), .brk(brk), .teq_trap(teq_trap), .eret(eret),
    .irq(irq), .status(status), .epc_in(epc_in), .take(take),
    .exception(exception), .cp0_eret(cp0_eret), .cause(cause),
    .epc_pc(epc_pc), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .stall(stall), .irq_pending(irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    instr_valid = 1'b0; syscall = 1'b0; brk = 1'b0; teq_trap = 1'b0; eret = 1'b0;
  endtask

  task automatic pulse_irq(input logic [2:0] k);
    @(negedge clk); irq[k] = 1'b1;
    repeat (4) @(negedge clk);
    irq[k] = 1'b0;
    repeat (3) @(negedge clk);
    m_pend[k] = 1'b1;
  endtask

  // Reference: expectations derived from priority rules and cause arithmetic.
  task automatic model_commit(input logic [31:0] st, input logic [31:0] pc,
                              input logic sy, input logic bp, input logic tr,
                              input logic er, input logic [31:0] epc_v);
    logic        ie, e_sy, e_bp, e_tr, e_int, e_take;
    int          code;
    logic [31:0] exp_cause, exp_epc, epc2;
    ie     = st[0];
    e_sy   = sy & ie & st[1];
    e_bp   = bp & ie & st[2];
    e_tr   = tr & ie & st[3];
    e_int  = (m_pend != 6'd0) & ie & st[4];
    e_take = e_sy | e_bp | e_tr | e_int;
    code   = e_sy ? 8 : e_bp ? 9 : e_tr ? 13 : 0;
    exp_cause = 32'(code) * 32'd4 + 32'(m_pend) * 32'd1024;
    exp_epc   = (e_sy | e_bp | e_tr) ? pc + 32'd4 : pc;
    epc2      = $urandom;
    @(negedge clk);
    status = st; instr_pc = pc; syscall = sy; brk = bp; teq_trap = tr; eret = er;
    epc_in = epc_v; instr_valid = 1'b1;
    #1;
    check1("rnd_take", take, e_take);
    check32("rnd_pend", {26'b0, irq_pending}, {26'b0, m_pend});
    @(negedge clk);
    clear_inputs();
    if (e_take) begin
      check1("rnd_exc", exception, 1'b1);
      check32("rnd_cause", cause, exp_cause);
      check32("rnd_epc", epc_pc, exp_epc);
      check1("rnd_no_eret", cp0_eret, 1'b0);
      @(negedge clk);
      check1("rnd_vec_redir", pc_redirect, 1'b1);
      check32("rnd_vec_pc", redirect_pc, 32'h4);
      if (code == 0) m_pend = 6'd0;
      @(negedge clk);
      check1("rnd_idle_stall", stall, 1'b0);
      check32("rnd_pend_after", {26'b0, irq_pending}, {26'b0, m_pend});
    end else if (er) begin
      check1("rnd_eret", cp0_eret, 1'b1);
      check1("rnd_eret_stall", stall, 1'b1);
      epc_in = epc2;
      @(negedge clk);
      check1("rnd_ret_redir", pc_redirect, 1'b1);
      check32("rnd_ret_pc", redirect_pc, epc2);
      @(negedge clk);
      check1("rnd_ret_idle", stall, 1'b0);
      check32("rnd_ret_hold", redirect_pc, epc2);
    end else begin
      check1("rnd_none_stall", stall, 1'b0);
      check1("rnd_none_exc", exception, 1'b0);
      check1("rnd_none_eret", cp0_eret, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r_st, r_pc, r_tmp;
    n_assert = 0; n_fail = 0; m_pend = 6'd0;
    rst = 1'b0; irq = 6'd0; status = 32'd0; instr_pc = 32'd0; epc_in = 32'd0;
    clear_inputs();
    #2;
    check1("rst_take", take, 1'b0);
    check1("rst_exc", exception, 1'b0);
    check1("rst_eret", cp0_eret, 1'b0);
    check1("rst_redir", pc_redirect, 1'b0);
    check1("rst_stall", stall, 1'b0);
    check32("rst_cause", cause, 32'd0);
    check32("rst_epc", epc_pc, 32'd0);
    check32("rst_rpc", redirect_pc, 32'd0);
    check32("rst_pend", {26'b0, irq_pending}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Syscall taken
    @(negedge clk);
    status = 32'h3; instr_pc = 32'h0040_0010; syscall = 1'b1; instr_valid = 1'b1;
    #1 check1("sys_take", take, 1'b1);
    check1("sys_stall0", stall, 1'b0);
    @(negedge clk); clear_inputs();
    check1("sys_exc", exception, 1'b1);
    check32("sys_cause", cause, 32'h20);
    check32("sys_epc", epc_pc, 32'h0040_0014);
    @(negedge clk);
    check1("sys_redir", pc_redirect, 1'b1);
    check32("sys_rpc", redirect_pc, 32'h4);
    check1("sys_exc_off", exception, 1'b0);
    @(negedge clk);
    check1("sys_idle", stall, 1'b0);
    check32("sys_cause_hold", cause, 32'h20);

    // Masked break
    @(negedge clk);
    status = 32'h1; brk = 1'b1; instr_valid = 1'b1;
    #1 check1("mask_take", take, 1'b0);
    @(negedge clk); clear_inputs();
    check1("mask_exc", exception, 1'b0);
    check1("mask_stall", stall, 1'b0);
    check1("mask_redir", pc_redirect, 1'b0);

    // Interrupt latency, then priority of syscall over a pending irq
    @(negedge clk); irq[2] = 1'b1;
    @(negedge clk); check32("irq_lat1", {26'b0, irq_pending}, 32'd0);
    @(negedge clk); check32("irq_lat2", {26'b0, irq_pending}, 32'd0);
    @(negedge clk); check32("irq_lat3", {26'b0, irq_pending}, 32'h4);
    irq[2] = 1'b0;
    repeat (2) @(negedge clk);
    status = 32'h1F; syscall = 1'b1; teq_trap = 1'b1; instr_pc = 32'h0040_0100; instr_valid = 1'b1;
    #1 check1("pri_take", take, 1'b1);
    @(negedge clk); clear_inputs();
    check32("pri_cause", cause, 32'h1020);
    check32("pri_epc", epc_pc, 32'h0040_0104);
    repeat (2) @(negedge clk);
    check32("pri_pend_kept", {26'b0, irq_pending}, 32'h4);
    instr_pc = 32'h0040_0200; instr_valid = 1'b1;
    #1 check1("int_take", take, 1'b1);
    @(negedge clk); clear_inputs();
    check32("int_cause", cause, 32'h1000);
    check32("int_epc", epc_pc, 32'h0040_0200);
    repeat (2) @(negedge clk);
    check32("int_pend_clr", {26'b0, irq_pending}, 32'd0);

    // Eret
    epc_in = 32'h0040_0014; eret = 1'b1; instr_valid = 1'b1;
    #1 check1("eret_take", take, 1'b0);
    check1("eret_stall0", stall, 1'b0);
    @(negedge clk); clear_inputs();
    check1("eret_strobe", cp0_eret, 1'b1);
    check1("eret_stall1", stall, 1'b1);
    check1("eret_noredir", pc_redirect, 1'b0);
    @(negedge clk);
    check1("eret_strobe_off", cp0_eret, 1'b0);
    check1("eret_redir", pc_redirect, 1'b1);
    check32("eret_rpc", redirect_pc, 32'h0040_0014);
    check1("eret_stall2", stall, 1'b1);
    @(negedge clk);
    check1("eret_stall3", stall, 1'b0);

    // Trap and eret together at the top of the address space
    status = 32'h5; brk = 1'b1; eret = 1'b1; instr_pc = 32'hFFFF_FFFC; instr_valid = 1'b1;
    #1 check1("both_take", take, 1'b1);
    @(negedge clk); clear_inputs();
    check1("both_exc", exception, 1'b1);
    check1("both_no_eret", cp0_eret, 1'b0);
    check32("wrap_cause", cause, 32'h24);
    check32("wrap_epc", epc_pc, 32'h0);
    @(negedge clk);
    check32("both_rpc", redirect_pc, 32'h4);
    @(negedge clk);

    // Edge landing in the VECTOR cycle survives the clear
    pulse_irq(3'd1);
    status = 32'h11; instr_pc = 32'h0000_0500; instr_valid = 1'b1; irq[1] = 1'b1;
    #1 check1("race_take", take, 1'b1);
    @(negedge clk); clear_inputs();
    check32("race_cause", cause, 32'h800);
    @(negedge clk);
    check1("race_vector", pc_redirect, 1'b1);
    @(negedge clk);
    check32("race_pend", {26'b0, irq_pending}, 32'h2);
    irq[1] = 1'b0;

    // Reset during SAVE
    @(negedge clk);
    status = 32'h3; syscall = 1'b1; instr_pc = 32'h0000_0600; instr_valid = 1'b1;
    @(negedge clk); clear_inputs();
    check1("mid_exc", exception, 1'b1);
    #1 rst = 1'b0;
    #1;
    check1("mid_exc_drop", exception, 1'b0);
    check1("mid_stall", stall, 1'b0);
    check1("mid_redir", pc_redirect, 1'b0);
    check32("mid_cause", cause, 32'd0);
    check32("mid_epc", epc_pc, 32'd0);
    check32("mid_pend", {26'b0, irq_pending}, 32'd0);
    @(negedge clk); rst = 1'b1; m_pend = 6'd0;
    @(negedge clk);
    status = 32'h5; brk = 1'b1; instr_pc = 32'h0000_0700; instr_valid = 1'b1;
    #1 check1("post_take", take, 1'b1);
    @(negedge clk); clear_inputs();
    check1("post_exc", exception, 1'b1);
    check32("post_cause", cause, 32'h24);
    check32("post_epc", epc_pc, 32'h0000_0704);
    repeat (2) @(negedge clk);

    // Randomized commits against the model
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) pulse_irq(3'($urandom_range(0, 5)));
      r_tmp = $urandom;
      r_st  = {27'b0, r_tmp[4:1], (r_tmp[7:5] != 3'd0)};
      r_pc  = $urandom;
      r_pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : (r_pc & 32'hFFFF_FFFC);
      model_commit(r_st, r_pc, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
